sm4_key_expand: RTL and testbench

Iterative SM4 key-expansion engine. It accepts a 128-bit master key, generates the 32 round keys rk0..rk31 at one per clock, and holds them in an internal store. The cipher datapath reads them back by round index, in forward order for encryption or reverse order for decryption. It is the consumer of the CK round-constant sequence, and it produces CK_i internally from the round counter.

---
 rtl/sm4_pkg.sv | 23 ++
 rtl/sm4_sbox.sv | 28 ++
 rtl/sm4_key_expand.sv | 133 +++++++++++++
 tb/tb_sm4_key_expand.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants, FSM state type and the L' linear transform.
package sm4_pkg;

    localparam int unsigned NumRounds = 32;
    localparam int unsigned WordWidth = 32;

    localparam logic [WordWidth-1:0] FK0 = 32'ha3b1bac6;
    localparam logic [WordWidth-1:0] FK1 = 32'h56aa3350;
    localparam logic [WordWidth-1:0] FK2 = 32'h677d9197;
    localparam logic [WordWidth-1:0] FK3 = 32'hb27022dc;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StDone
    } state_e;

    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    function automatic logic [WordWidth-1:0] l_prime(input logic [WordWidth-1:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_sbox.sv
// SM4 8-bit S-box, pure combinational table lookup.
module sm4_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [0:255][7:0] Sbox = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    assign out_byte = Sbox[in_byte];

endmodule

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key expansion: one round key per cycle into a 32-word store read by round.
// Define SM4_KEY_CLEAR_EN to add the clear_in zeroize pulse and a reset on the key store.
module sm4_key_expand
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         keys_valid,
    input  logic         decrypt_in,
    input  logic [4:0]   round_in,
`ifdef SM4_KEY_CLEAR_EN
    input  logic         clear_in,
`endif
    output logic [31:0]  rk_out
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        keys_valid_q, keys_valid_d;
    logic [31:0] k_q [4];
    logic [31:0] k_d [4];
    logic [31:0] store_q [NumRounds];
    logic [31:0] rk_out_q;
    logic [31:0] ck, sbox_in, sbox_out, rk_new;
    logic [7:0]  ck_base;
    logic [4:0]  rd_idx;
    logic        store_we, clear;

`ifdef SM4_KEY_CLEAR_EN
    assign clear = clear_in;
`else
    assign clear = 1'b0;
`endif

    // CK byte j = (4*cnt + j) * 7 mod 256, MSB first
    always_comb begin
        ck      = '0;
        ck_base = {1'b0, cnt_q, 2'b00};
        for (int j = 0; j < 4; j++) begin
            ck[8*(3-j) +: 8] = (ck_base + 8'(j)) * 8'd7;
        end
    end

    assign sbox_in = k_q[1] ^ k_q[2] ^ k_q[3] ^ ck;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sm4_sbox u_sbox (
            .in_byte  (sbox_in[8*g +: 8]),
            .out_byte (sbox_out[8*g +: 8])
        );
    end

    assign rk_new    = k_q[0] ^ l_prime(sbox_out);
    assign key_ready = (state_q != StExpand) && !clear;
    assign rd_idx    = decrypt_in ? ~round_in : round_in;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        keys_valid_d = keys_valid_q;
        k_d          = k_q;
        store_we     = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (key_valid && key_ready) begin
                    k_d[0]       = key_in[127:96] ^ FK0;
                    k_d[1]       = key_in[95:64]  ^ FK1;
                    k_d[2]       = key_in[63:32]  ^ FK2;
                    k_d[3]       = key_in[31:0]   ^ FK3;
                    cnt_d        = '0;
                    keys_valid_d = 1'b0;
                    state_d      = StExpand;
                end
            end
            StExpand: begin
                store_we = 1'b1;
                k_d      = '{k_q[1], k_q[2], k_q[3], rk_new};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'(NumRounds - 1)) begin
                    keys_valid_d = 1'b1;
                    state_d      = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        // Zeroize overrides everything, including an in-flight expansion
        if (clear) begin
            store_we     = 1'b0;
            k_d          = '{default: '0};
            keys_valid_d = 1'b0;
            state_d      = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            keys_valid_q <= 1'b0;
            rk_out_q     <= '0;
            for (int i = 0; i < 4; i++) k_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            keys_valid_q <= keys_valid_d;
            rk_out_q     <= store_q[rd_idx];
            k_q          <= k_d;
        end
    end

`ifdef SM4_KEY_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRounds; i++) store_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NumRounds; i++) store_q[i] <= '0;
        end else if (store_we) begin
            store_q[cnt_q] <= rk_new;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (store_we) store_q[cnt_q] <= rk_new;
    end
`endif

    assign keys_valid = keys_valid_q;
    assign rk_out     = rk_out_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Self-checking bench for sm4_key_expand against a whole-schedule SM4 reference model.
module tb_sm4_key_expand;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready, keys_valid;
    logic         decrypt_in = 1'b0;
    logic [4:0]   round_in = '0;
    logic [31:0]  rk_out;
    logic         clr_drv = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sm4_key_expand dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .decrypt_in (decrypt_in),
        .round_in   (round_in),
`ifdef SM4_KEY_CLEAR_EN
        .clear_in   (clr_drv),
`endif
        .rk_out     (rk_out)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] SboxRows [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Reference model state: store contents, which words are defined, pending schedule.
    logic [31:0] m_store [32];
    logic        m_known [32];
    logic [31:0] m_pend  [32];
    int          m_busy  = 0;
    logic        m_valid = 1'b0;

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [127:0] row;
        row = SboxRows[x[7:4]];
        return row[(15 - int'(x[3:0])) * 8 +: 8];
    endfunction

    function automatic logic [31:0] ck_model(input int c);
        logic [31:0] r = 0;
        for (int j = 0; j < 4; j++) r = (r << 8) | 32'(((4 * c + j) * 7) % 256);
        return r;
    endfunction

    function automatic logic [31:0] t_prime(input logic [31:0] x);
        logic [31:0] b;
        b = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
        return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
    endfunction

    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [127:0] kf;
        kf = mk ^ {32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
        for (int i = 0; i < 4; i++) k[i] = kf[127 - 32*i -: 32];
        for (int i = 0; i < 32; i++) begin
            k[i+4] = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_model(i));
            m_pend[i] = k[i+4];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then compare.
    task automatic step();
        int   idx;
        logic chk, kv, clr;
        logic [31:0] exp_rk;
        idx    = decrypt_in ? 31 - int'(round_in) : int'(round_in);
        chk    = m_known[idx];
        exp_rk = m_store[idx];
        kv     = key_valid;
        clr    = clr_drv;
        @(posedge clk);
        #1;
        if (clr) begin
            for (int i = 0; i < 32; i++) begin
                m_store[i] = '0;
                m_known[i] = 1'b1;
            end
            m_busy  = 0;
            m_valid = 1'b0;
        end else if (m_busy > 0) begin
            m_store[32 - m_busy] = m_pend[32 - m_busy];
            m_known[32 - m_busy] = 1'b1;
            m_busy--;
            if (m_busy == 0) m_valid = 1'b1;
        end else if (kv) begin
            model_expand(key_in);
            m_busy  = 32;
            m_valid = 1'b0;
        end
        check("key_ready", 32'(key_ready), 32'(m_busy == 0 && !clr_drv));
        check("keys_valid", 32'(keys_valid), 32'(m_valid));
        if (chk) check("rk_out", rk_out, exp_rk);
        if (m_busy > 0) check("ck", dut.ck, ck_model(32 - m_busy));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_key_ready", 32'(key_ready), 32'd1);
        check("rst_keys_valid", 32'(keys_valid), 32'd0);
        check("rst_rk_out", rk_out, 32'd0);
        rst_n   = 1'b1;
        m_busy  = 0;
        m_valid = 1'b0;
`ifdef SM4_KEY_CLEAR_EN
        for (int i = 0; i < 32; i++) begin
            m_store[i] = '0;
            m_known[i] = 1'b1;
        end
`endif
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!keys_valid && n < 40) begin
            step();
            n++;
        end
        if (!keys_valid) check(name, 32'(keys_valid), 32'd1);
    endtask

    task automatic read_check(input logic dec, input int r, input logic [31:0] exp, input string name);
        decrypt_in = dec;
        round_in   = 5'(r);
        step();
        check(name, rk_out, exp);
    endtask

    initial begin
        int low_cnt;
        for (int i = 0; i < 32; i++) begin
            m_store[i] = '0;
            m_known[i] = 1'b0;
        end
        // Pin the reference model with published values
        check("model_ck0", ck_model(0), 32'h00070e15);
        check("model_ck9", ck_model(9), 32'hfc030a11);
        check("model_ck31", ck_model(31), 32'h646b7279);
        model_expand(128'h0123456789abcdeffedcba9876543210);
        check("model_rk0", m_pend[0], 32'hf12186f9);
        check("model_rk1", m_pend[1], 32'h41662b61);
        check("model_rk31", m_pend[31], 32'h9124a012);

        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Known-answer expansion
        key_in    = 128'h0123456789abcdeffedcba9876543210;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int i = 0; i < 31; i++) begin
            round_in   = 5'($urandom);
            decrypt_in = 1'($urandom);
            step();
        end
        wait_valid("kat_valid");
        read_check(1'b0, 0, 32'hf12186f9, "enc_rk0");
        read_check(1'b0, 1, 32'h41662b61, "enc_rk1");
        read_check(1'b0, 31, 32'h9124a012, "enc_rk31");
        read_check(1'b1, 0, 32'h9124a012, "dec_r0");
        read_check(1'b1, 31, 32'hf12186f9, "dec_r31");

        // Handshake: second key held high through the whole expansion
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        step();
        low_cnt = key_ready ? 0 : 1;
        key_in  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 32; i++) begin
            round_in = 5'($urandom);
            step();
            if (!key_ready) low_cnt++;
        end
        check("ready_low_cycles", 32'(low_cnt), 32'd32);
        step();
        check("second_accept_drop", 32'(keys_valid), 32'd0);
        key_valid = 1'b0;
        wait_valid("second_valid");
        for (int r = 0; r < 32; r++) begin
            decrypt_in = 1'($urandom);
            round_in   = 5'(r);
            step();
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            key_valid  = ($urandom_range(0, 15) == 0);
            key_in     = {$urandom, $urandom, $urandom, $urandom};
            decrypt_in = 1'($urandom);
            round_in   = 5'($urandom);
            step();
        end
        key_valid = 1'b0;
        wait_valid("rand_valid");

        // Reset in the middle of an expansion (cnt = 10)
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (10) step();
        check("mid_cnt", 32'(dut.cnt_q), 32'd10);
        do_reset();
        repeat (3) step();

`ifdef SM4_KEY_CLEAR_EN
        key_in    = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        wait_valid("pre_clear_valid");
        clr_drv   = 1'b1;
        key_valid = 1'b1;
        step();
        clr_drv   = 1'b0;
        key_valid = 1'b0;
        step();
        check("clear_no_accept", 32'(key_ready), 32'd1);
        for (int r = 0; r < 32; r++) read_check(1'($urandom), r, 32'd0, "clear_zero");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
